// File: rtl/mesi_pkg.sv
// rtl/mesi_pkg.sv - shared MESI, snoop, bus-op, command and FSM encodings
package mesi_pkg;

  localparam int DEF_ADDR_W   = 32;
  localparam int DEF_OFFSET_W = 6;

  typedef enum logic [1:0] {
    MESI_I = 2'b00,
    MESI_S = 2'b01,
    MESI_E = 2'b10,
    MESI_M = 2'b11
  } mesi_t;

  typedef enum logic [1:0] {
    SNOOP_NOHIT = 2'b00,
    SNOOP_HIT   = 2'b01,
    SNOOP_HITM  = 2'b10,
    SNOOP_RSVD  = 2'b11
  } snoop_t;

  typedef enum logic [1:0] {
    BUS_NONE  = 2'b00,
    BUS_READ  = 2'b01,
    BUS_WRITE = 2'b10,
    BUS_RFO   = 2'b11
  } bus_op_t;

  typedef enum logic [1:0] {
    FSM_IDLE = 2'b00,
    FSM_BUS  = 2'b01,
    FSM_DONE = 2'b10
  } fsm_t;

  localparam logic [3:0] CMD_READ_DATA  = 4'd0;
  localparam logic [3:0] CMD_WRITE_DATA = 4'd1;
  localparam logic [3:0] CMD_READ_INSTR = 4'd2;
  localparam logic [3:0] CMD_SNOOP_INV  = 4'd3;
  localparam logic [3:0] CMD_SNOOP_READ = 4'd4;
  localparam logic [3:0] CMD_SNOOP_WR   = 4'd5;
  localparam logic [3:0] CMD_SNOOP_RFO  = 4'd6;
  localparam logic [3:0] CMD_CLEAR      = 4'd8;
  localparam logic [3:0] CMD_PRINT      = 4'd9;

  // Snoop response this cache advertises for a line it holds in state s.
  function automatic logic [1:0] snoop_response(input logic [1:0] s);
    case (s)
      MESI_M:         snoop_response = SNOOP_HITM;
      MESI_E, MESI_S: snoop_response = SNOOP_HIT;
      default:        snoop_response = SNOOP_NOHIT;
    endcase
  endfunction

endpackage

// File: rtl/mesi_next_state.sv
// rtl/mesi_next_state.sv - combinational MESI next-state and bus-op table
module mesi_next_state
  import mesi_pkg::*;
(
  input  logic [1:0] state,
  input  logic [3:0] cmd,
  input  logic [1:0] snoop,
  output logic [1:0] next_state,
  output logic [1:0] bus_op
);

  logic other_has_copy;
  assign other_has_copy = (snoop == SNOOP_HIT) || (snoop == SNOOP_HITM);

  always_comb begin
    next_state = state;
    bus_op     = BUS_NONE;
    case (cmd)
      CMD_READ_DATA, CMD_READ_INSTR: begin
        if (state == MESI_I) begin
          next_state = other_has_copy ? MESI_S : MESI_E;
          bus_op     = BUS_READ;
        end
      end
      CMD_WRITE_DATA: begin
        next_state = MESI_M;
        // Only E and M already own the line exclusively.
        if (state == MESI_I || state == MESI_S) bus_op = BUS_RFO;
      end
      CMD_SNOOP_INV, CMD_SNOOP_RFO: begin
        next_state = MESI_I;
        if (state == MESI_M) bus_op = BUS_WRITE;
      end
      CMD_SNOOP_READ: begin
        if (state == MESI_M) begin
          next_state = MESI_S;
          bus_op     = BUS_WRITE;
        end else if (state == MESI_E) begin
          next_state = MESI_S;
        end
      end
      CMD_CLEAR: next_state = MESI_I;
      default: begin
        next_state = state;
        bus_op     = BUS_NONE;
      end
    endcase
  end

endmodule

// File: rtl/bus_operation.sv
// rtl/bus_operation.sv - per-access MESI engine driving one system-bus transaction
module bus_operation
  import mesi_pkg::*;
#(
  parameter int ADDR_W   = DEF_ADDR_W,
  parameter int OFFSET_W = DEF_OFFSET_W
) (
  input  logic              clk,
  input  logic              rst,
  input  logic              req_valid,
  output logic              req_ready,
  input  logic [3:0]        req_cmd,
  input  logic [1:0]        req_state,
  input  logic [1:0]        req_snoop,
  input  logic [ADDR_W-1:0] req_addr,
  output logic              bus_valid,
  output logic [1:0]        bus_op,
  output logic [ADDR_W-1:0] bus_addr,
  input  logic              bus_ack,
  output logic              done,
  output logic [1:0]        next_state,
  output logic [1:0]        put_snoop
);

  localparam logic [ADDR_W-1:0] LINE_MASK = {ADDR_W{1'b1}} << OFFSET_W;

  fsm_t              fsm_q, fsm_d;
  logic [1:0]        tbl_state, tbl_op;
  logic [1:0]        ns_q, op_q;
  logic [ADDR_W-1:0] addr_q;
  logic              accept;

  mesi_next_state u_table (
    .state      (req_state),
    .cmd        (req_cmd),
    .snoop      (req_snoop),
    .next_state (tbl_state),
    .bus_op     (tbl_op)
  );

  assign accept = (fsm_q == FSM_IDLE) && req_valid;

  always_ff @(posedge clk or posedge rst) begin
    if (rst) fsm_q <= FSM_IDLE;
    else     fsm_q <= fsm_d;
  end

  always_comb begin
    fsm_d = fsm_q;
    case (fsm_q)
      FSM_IDLE: if (req_valid) fsm_d = (tbl_op == BUS_NONE) ? FSM_DONE : FSM_BUS;
      FSM_BUS:  if (bus_ack) fsm_d = FSM_DONE;
      FSM_DONE: fsm_d = FSM_IDLE;
      default:  fsm_d = FSM_IDLE;
    endcase
  end

  // Table result is captured at acceptance so bus_op/bus_addr stay stable in BUS.
  always_ff @(posedge clk or posedge rst) begin
    if (rst) begin
      ns_q   <= MESI_I;
      op_q   <= BUS_NONE;
      addr_q <= '0;
    end else if (accept) begin
      ns_q   <= tbl_state;
      op_q   <= tbl_op;
      addr_q <= req_addr & LINE_MASK;
    end
  end

  always_comb begin
    req_ready  = (fsm_q == FSM_IDLE);
    bus_valid  = (fsm_q == FSM_BUS);
    bus_op     = (fsm_q == FSM_BUS) ? op_q : BUS_NONE;
    done       = (fsm_q == FSM_DONE);
    bus_addr   = addr_q;
    next_state = ns_q;
  end

  assign put_snoop = snoop_response(req_state);

endmodule

// File: tb/tb_bus_operation.sv
// tb/tb_bus_operation.sv - self-checking bench for bus_operation
module tb_bus_operation;

  logic        clk = 1'b0;
  logic        rst = 1'b1;
  logic        req_valid = 1'b0;
  logic        req_ready;
  logic [3:0]  req_cmd = 4'd0;
  logic [1:0]  req_state = 2'd0;
  logic [1:0]  req_snoop = 2'd0;
  logic [31:0] req_addr = 32'd0;
  logic        bus_valid;
  logic [1:0]  bus_op;
  logic [31:0] bus_addr;
  logic        bus_ack = 1'b0;
  logic        done;
  logic [1:0]  next_state;
  logic [1:0]  put_snoop;

  int checks = 0;
  int errors = 0;

  bus_operation #(.ADDR_W(32), .OFFSET_W(6)) dut (
    .clk        (clk),
    .rst        (rst),
    .req_valid  (req_valid),
    .req_ready  (req_ready),
    .req_cmd    (req_cmd),
    .req_state  (req_state),
    .req_snoop  (req_snoop),
    .req_addr   (req_addr),
    .bus_valid  (bus_valid),
    .bus_op     (bus_op),
    .bus_addr   (bus_addr),
    .bus_ack    (bus_ack),
    .done       (done),
    .next_state (next_state),
    .put_snoop  (put_snoop)
  );

  always #5 clk = ~clk;

  typedef struct {
    logic [1:0]  st;
    logic [3:0]  cmd;
    logic [1:0]  sn;
    logic [31:0] addr;
    logic [1:0]  ns;
    logic [1:0]  op;
  } vec_t;

  vec_t vecs[$];

  task automatic chk(input string name, input logic [31:0] act, input logic [31:0] exp);
    checks++;
    if (act !== exp) begin
      errors++;
      $display("FAIL %s: got %0h expected %0h", name, act, exp);
    end
  endtask

  // Reference: MESI rules expressed by access kind rather than as a state table.
  task automatic model(input logic [1:0] st, input logic [3:0] cmd, input logic [1:0] sn,
                       output logic [1:0] ns, output logic [1:0] op);
    bit shared_elsewhere = (sn == 2'd1) || (sn == 2'd2);
    bit valid_line = (st != 2'd0);
    bit dirty      = (st == 2'd3);
    ns = st;
    op = 2'd0;
    if (cmd == 0 || cmd == 2) begin
      if (!valid_line) begin ns = shared_elsewhere ? 2'd1 : 2'd2; op = 2'd1; end
    end else if (cmd == 1) begin
      ns = 2'd3;
      if (st == 2'd0 || st == 2'd1) op = 2'd3;
    end else if (cmd == 3 || cmd == 6) begin
      ns = 2'd0;
      if (dirty) op = 2'd2;
    end else if (cmd == 4) begin
      if (st >= 2'd2) ns = 2'd1;
      if (dirty) op = 2'd2;
    end else if (cmd == 8) begin
      ns = 2'd0;
    end
  endtask

  function automatic logic [1:0] exp_snoop(input logic [1:0] st);
    if (st == 2'd3) return 2'd2;
    if (st == 2'd0) return 2'd0;
    return 2'd1;
  endfunction

  task automatic do_access(input logic [1:0] st, input logic [3:0] cmd, input logic [1:0] sn,
                           input logic [31:0] addr, input logic [1:0] ens, input logic [1:0] eop,
                           input int ack_dly, input logic ack_noise);
    @(negedge clk);
    chk("ready_idle", req_ready, 1'b1);
    chk("done_idle", done, 1'b0);
    req_valid = 1'b1;
    req_state = st; req_cmd = cmd; req_snoop = sn; req_addr = addr;
    bus_ack = ack_noise;
    #1 chk("put_snoop", put_snoop, exp_snoop(st));
    @(negedge clk);
    req_valid = 1'b0;
    bus_ack = 1'b0;
    chk("ready_busy", req_ready, 1'b0);
    if (eop == 2'd0) begin
      chk("nobus_valid", bus_valid, 1'b0);
      chk("nobus_done", done, 1'b1);
      chk("nobus_state", next_state, ens);
    end else begin
      chk("bus_valid", bus_valid, 1'b1);
      chk("bus_op", bus_op, eop);
      chk("bus_addr", bus_addr, addr & 32'hFFFF_FFC0);
      chk("bus_done_early", done, 1'b0);
      for (int i = 0; i < ack_dly; i++) begin
        @(negedge clk);
        chk("bus_hold_valid", bus_valid, 1'b1);
        chk("bus_hold_op", bus_op, eop);
        chk("bus_hold_addr", bus_addr, addr & 32'hFFFF_FFC0);
      end
      bus_ack = 1'b1;
      @(negedge clk);
      bus_ack = 1'b0;
      chk("ack_done", done, 1'b1);
      chk("ack_valid_drop", bus_valid, 1'b0);
      chk("ack_state", next_state, ens);
    end
  endtask

  function automatic vec_t mk(input logic [1:0] st, input logic [3:0] cmd, input logic [1:0] sn,
                              input logic [31:0] addr, input logic [1:0] ns, input logic [1:0] op);
    vec_t v;
    v.st = st; v.cmd = cmd; v.sn = sn; v.addr = addr; v.ns = ns; v.op = op;
    return v;
  endfunction

  initial begin
    logic [1:0] rns, rop;

    vecs.push_back(mk(2'd0, 4'd0, 2'd0, 32'h1234_5678, 2'd2, 2'd1));
    vecs.push_back(mk(2'd0, 4'd2, 2'd2, 32'h0000_1040, 2'd1, 2'd1));
    vecs.push_back(mk(2'd0, 4'd2, 2'd1, 32'hFFFF_FFFF, 2'd1, 2'd1));
    vecs.push_back(mk(2'd1, 4'd1, 2'd0, 32'hDEAD_BEEF, 2'd3, 2'd3));
    vecs.push_back(mk(2'd2, 4'd1, 2'd0, 32'h0000_0001, 2'd3, 2'd0));
    vecs.push_back(mk(2'd3, 4'd4, 2'd0, 32'hA5A5_A5A5, 2'd1, 2'd2));
    vecs.push_back(mk(2'd3, 4'd6, 2'd0, 32'h0BAD_F00D, 2'd0, 2'd2));
    vecs.push_back(mk(2'd0, 4'd8, 2'd0, 32'h0000_0100, 2'd0, 2'd0));
    vecs.push_back(mk(2'd1, 4'd8, 2'd1, 32'h0000_0200, 2'd0, 2'd0));
    vecs.push_back(mk(2'd2, 4'd8, 2'd2, 32'h0000_0300, 2'd0, 2'd0));
    vecs.push_back(mk(2'd3, 4'd8, 2'd0, 32'h0000_0400, 2'd0, 2'd0));
    vecs.push_back(mk(2'd2, 4'd9, 2'd0, 32'h0000_0500, 2'd2, 2'd0));
    vecs.push_back(mk(2'd1, 4'd7, 2'd0, 32'h0000_0600, 2'd1, 2'd0));
    vecs.push_back(mk(2'd0, 4'd0, 2'd3, 32'h8000_003F, 2'd2, 2'd1));
    vecs.push_back(mk(2'd3, 4'd3, 2'd1, 32'h4000_0040, 2'd0, 2'd2));
    vecs.push_back(mk(2'd2, 4'd4, 2'd0, 32'h0000_0700, 2'd1, 2'd0));
    vecs.push_back(mk(2'd1, 4'd5, 2'd0, 32'h0000_0800, 2'd1, 2'd0));
    vecs.push_back(mk(2'd0, 4'd15, 2'd0, 32'h0000_0900, 2'd0, 2'd0));
    vecs.push_back(mk(2'd3, 4'd0, 2'd2, 32'h0000_0A00, 2'd3, 2'd0));

    #2;
    chk("rst_ready", req_ready, 1'b1);
    chk("rst_bus_valid", bus_valid, 1'b0);
    chk("rst_bus_op", bus_op, 2'd0);
    chk("rst_bus_addr", bus_addr, 32'd0);
    chk("rst_done", done, 1'b0);
    chk("rst_next_state", next_state, 2'd0);
    @(negedge clk);
    rst = 1'b0;

    foreach (vecs[i])
      do_access(vecs[i].st, vecs[i].cmd, vecs[i].sn, vecs[i].addr, vecs[i].ns, vecs[i].op, i % 3, 1'b0);

    // Reset while a bus transaction is waiting on a withheld ack.
    @(negedge clk);
    req_valid = 1'b1; req_state = 2'd1; req_cmd = 4'd1; req_snoop = 2'd0; req_addr = 32'h0000_2080;
    @(negedge clk);
    req_valid = 1'b0;
    chk("pre_rst_bus_valid", bus_valid, 1'b1);
    @(negedge clk);
    rst = 1'b1;
    #1;
    chk("mid_rst_bus_valid", bus_valid, 1'b0);
    chk("mid_rst_ready", req_ready, 1'b1);
    chk("mid_rst_bus_op", bus_op, 2'd0);
    chk("mid_rst_done", done, 1'b0);
    @(negedge clk);
    rst = 1'b0;
    do_access(2'd0, 4'd0, 2'd1, 32'h0000_3000, 2'd1, 2'd1, 1, 1'b0);

    // Randomized accesses against the reference model; stray acks outside BUS.
    for (int n = 0; n < 60; n++) begin
      logic [1:0]  st  = 2'($urandom_range(0, 3));
      logic [3:0]  cmd = 4'($urandom_range(0, 15));
      logic [1:0]  sn  = 2'($urandom_range(0, 3));
      logic [31:0] ad  = $urandom;
      model(st, cmd, sn, rns, rop);
      do_access(st, cmd, sn, ad, rns, rop, int'($urandom_range(0, 3)), 1'($urandom_range(0, 1)));
    end

    @(negedge clk);
    chk("final_ready", req_ready, 1'b1);
    $display("Result: errors=%0d of %0d checks", errors, checks);
    $finish;
  end

endmodule

// File: doc/bus_operation.md
Name: bus_operation

Overview:
- Synthesizable per-access MESI protocol engine for the split L2 cache.
- Takes one access, consisting of the line's current MESI state, a trace command, the snoop result and the address.
- Computes the line's next MESI state and the required bus transaction, then runs that transaction on the system bus with a valid/ack handshake.
- Sits between the cache tag/state array and the system-bus interface. Also reports the snoop response this cache gives for the addressed line.

Parameters:
- ADDR_W, 32, physical address width.
- OFFSET_W, 6, byte-offset bits of a line; zeroed in bus_addr.

Ports:
- clk  in  1  system clock; all state updates on the rising edge.
- rst  in  1  asynchronous, active-high reset.
- req_valid  in  1  access request present.
- req_ready  out  1  engine idle and able to accept a request.
- req_cmd  in  4  trace command.
- req_state  in  2  current MESI state of the line.
- req_snoop  in  2  snoop result from other caches.
- req_addr  in  ADDR_W  access address.
- bus_valid  out  1  bus transaction pending.
- bus_op  out  2  bus transaction code.
- bus_addr  out  ADDR_W  line address: req_addr with the low OFFSET_W bits forced to 0.
- bus_ack  in  1  bus accepted the transaction.
- done  out  1  one-cycle completion pulse.
- next_state  out  2  resulting MESI state; valid while done=1.
- put_snoop  out  2  combinational snoop response for req_state.

Behaviour:
- Encodings, all stored in the shared package:
  - MESI: I=00, S=01, E=10, M=11.
  - Snoop result: NOHIT=00, HIT=01, HITM=10; 11 is treated as NOHIT.
  - Bus op: NONE=00, READ=01, WRITE=10, RFO=11.
  - Commands: 0 read data, 1 write data, 2 read instruction, 3 snoop invalidate, 4 snoop read, 5 snoop write, 6 snoop RFO, 8 clear, 9 print.
- Next-state table (state/command -> next state, bus op):
  - I, read (0/2) -> E with READ when snoop is NOHIT; -> S with READ when snoop is HIT or HITM.
  - I, write (1) -> M with RFO.
  - S, read -> S, NONE. S, write -> M, RFO.
  - E, read -> E, NONE. E, write -> M, NONE.
  - M, read or write -> M, NONE.
  - Command 3 or 6: S/E -> I, NONE; M -> I, WRITE (writeback); I -> I, NONE.
  - Command 4: M -> S, WRITE; E -> S, NONE; S and I unchanged, NONE.
  - Command 5: no state change, NONE.
  - Command 8: any state -> I, NONE.
  - Command 9 and undefined codes (7, 10–15): no state change, NONE.
- put_snoop: M -> HITM; E or S -> HIT; I -> NOHIT. Purely combinational on req_state.
- FSM states IDLE, BUS, DONE:
  - IDLE: req_ready=1. On req_valid, latch the request and compute the table result; the table is a combinational sub-module.
    - If the bus op is NONE, go to DONE.
    - Otherwise go to BUS.
  - BUS: bus_valid=1; bus_op and bus_addr are held stable. When bus_ack is sampled high, go to DONE.
  - DONE: done=1 and next_state is valid for exactly one cycle; then return to IDLE.
- Latency:
  - Accesses needing no bus op: done asserts 1 cycle after acceptance.
  - Accesses needing a bus op: bus_valid asserts 1 cycle after acceptance; done asserts the cycle after the ack is sampled.
- bus_ack is ignored outside BUS. req_valid is ignored while req_ready=0.
- A request is accepted in the same cycle that DONE returns the FSM to IDLE only if req_ready is high, i.e. the cycle after done.
- Reset: FSM goes to IDLE immediately, even mid-transaction; an outstanding bus transaction is abandoned. Reset values: req_ready=1, bus_valid=0, bus_op=NONE, bus_addr=0, done=0, next_state=I.

Decomposition:
- Package mesi_pkg: MESI, snoop, bus-op and command encodings, plus ADDR_W/OFFSET_W defaults.
- One combinational sub-module, mesi_next_state: inputs state, cmd, snoop; outputs next state and bus op.

Test Plan:
- state=I, cmd=0, snoop=NOHIT, addr=0x1234_5678 -> bus_valid with bus_op=READ and bus_addr=0x1234_5640; ack -> done, next_state=E.
- state=I, cmd=2, snoop=HITM -> READ; next_state=S. Repeat with snoop=HIT -> S.
- state=S, cmd=1 -> RFO, next_state=M. Then state=E, cmd=1 -> done after 1 cycle with no bus_valid, next_state=M.
- state=M, cmd=4 -> WRITE, next_state=S. state=M, cmd=6 -> WRITE, next_state=I. put_snoop=HITM while req_state=M.
- cmd=8 with each of the four states -> next_state=I with no bus op. cmd=9 and cmd=7 -> state unchanged.
- Assert rst while in BUS with ack withheld -> bus_valid=0 and req_ready=1 immediately. A subsequent request executes normally.
